// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic op_signed(input logic [1:0] o);
    return (o == DIV) || (o == REM);
  endfunction

  function automatic logic op_rem(input logic [1:0] o);
    return (o == REM) || (o == REMU);
  endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit adder built from eight 4-bit carry-lookahead groups rippling between groups.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       ci;
    logic       co;

    if (gi == 0) begin : g_first
      assign ci = c_in;
    end else begin : g_rest
      assign ci = g_grp[gi-1].co;
    end

    assign g = a[4*gi +: 4] & b[4*gi +: 4];
    assign p = a[4*gi +: 4] ^ b[4*gi +: 4];

    // every carry is expanded directly from ci so no bit depends on a sibling bit
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign sum[4*gi +: 4] = p ^ c;
  end

  assign c_out = g_grp[7].co;

endmodule

// File: rtl/div32_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: 32 iterations plus a sign-fix
// cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module div32_seq
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0]       S_IDLE   = IDLE;
  localparam logic [1:0]       S_CALC   = CALC;
  localparam logic [1:0]       S_FIX    = FIX;
  localparam logic [1:0]       S_DONE   = DONE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_reg,  state_next;
  logic [1:0]       op_reg,     op_next;
  logic             sign_a_reg, sign_a_next;
  logic             sign_b_reg, sign_b_next;
  logic [XLEN-1:0]  rem_reg,    rem_next;
  logic [XLEN-1:0]  quo_reg,    quo_next;
  logic [XLEN-1:0]  dsr_reg,    dsr_next;
  logic [XLEN-1:0]  result_reg, result_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;

  logic            in_signed;
  logic            in_rem;
  logic            neg_a;
  logic            neg_b;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] fast_val;

  assign in_signed = op_signed(op);
  assign in_rem    = op_rem(op);
  assign neg_a     = in_signed & dividend[XLEN-1];
  assign neg_b     = in_signed & divisor[XLEN-1];
  assign abs_a     = neg_a ? neg32(dividend) : dividend;
  assign abs_b     = neg_b ? neg32(divisor)  : divisor;
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = in_signed & (dividend == INT_MIN) & (divisor == '1);

  always_comb begin
    fast_val = '0;
    if (div_zero) begin
      fast_val = in_rem ? dividend : DIV0_QUO;
    end else if (!in_rem) begin
      fast_val = INT_MIN;
    end
  end

  logic [XLEN-1:0] rem_shift;
  logic [XLEN-1:0] dsr_inv;
  logic [XLEN-1:0] trial;
  logic            carry;
  logic            ovf_bit;
  logic            take;
  logic [XLEN-1:0] rem_iter;
  logic [XLEN-1:0] quo_iter;

  assign rem_shift = {rem_reg[XLEN-2:0], quo_reg[XLEN-1]};
  assign ovf_bit   = rem_reg[XLEN-1];
  assign dsr_inv   = ~dsr_reg;

  adder32 u_sub (
    .a     (rem_shift),
    .b     (dsr_inv),
    .c_in  (1'b1),
    .sum   (trial),
    .c_out (carry)
  );

  // a bit shifted out of the top means the partial remainder already exceeds any divisor
  assign take     = ovf_bit | carry;
  assign rem_iter = take ? trial : rem_shift;
  assign quo_iter = {quo_reg[XLEN-2:0], take};

  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_val;

  assign quo_fix = (sign_a_reg ^ sign_b_reg) ? neg32(quo_reg) : quo_reg;
  assign rem_fix = sign_a_reg ? neg32(rem_reg) : rem_reg;
  assign fix_val = op_rem(op_reg) ? rem_fix : quo_fix;

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    dsr_next    = dsr_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (start) begin
          op_next     = op;
          sign_a_next = neg_a;
          sign_b_next = neg_b;
          rem_next    = '0;
          quo_next    = abs_a;
          dsr_next    = abs_b;
          cnt_next    = '0;
          if (div_zero || sgn_ovf) begin
            result_next = fast_val;
            state_next  = S_DONE;
          end else begin
            state_next  = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_next = rem_iter;
        quo_next = quo_iter;
        cnt_next = cnt_reg + CNT_ONE;
        if (cnt_reg == CNT_LAST) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        result_next = fix_val;
        state_next  = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dsr_reg    <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      dsr_reg    <= dsr_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign busy   = (state_reg == S_CALC) || (state_reg == S_FIX);
  assign valid  = (state_reg == S_DONE);
  assign result = result_reg;

endmodule
